// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Shared definitions for the SPI control register bank: frame layout,
// register addresses, configuration record with its reset defaults, the
// receive FSM state encoding and the register-write helper.
// No ports (package).
package ctrl_pkg;

  localparam int FRAME_BITS = 24;

  // Field widths of the configuration record (module parameters default to these)
  localparam int CFG_A_BITS  = 3;
  localparam int CFG_BLEND_B = 4;
  localparam int CFG_DLY_B   = 14;
  localparam int CFG_FDB_B   = 10;

  localparam logic [2:0] ADDR_DRAW  = 3'd0;
  localparam logic [2:0] ADDR_BLEND = 3'd1;
  localparam logic [2:0] ADDR_DELAY = 3'd2;
  localparam logic [2:0] ADDR_FDBK  = 3'd3;
  localparam logic [2:0] ADDR_CMD   = 3'd4;

  localparam logic [CFG_A_BITS-1:0]  RST_A16    = 3'd7;
  localparam logic [CFG_A_BITS-1:0]  RST_A8     = 3'd4;
  localparam logic [CFG_A_BITS-1:0]  RST_A5     = 3'd0;
  localparam logic [CFG_A_BITS-1:0]  RST_A4     = 3'd0;
  localparam logic [CFG_BLEND_B-1:0] RST_BLEND  = 4'd0;
  localparam logic [CFG_DLY_B-1:0]   RST_DELAY  = 14'd0;
  localparam logic [CFG_FDB_B-1:0]   RST_FEEDBK = 10'd0;

  typedef struct packed {
    logic [CFG_A_BITS-1:0]  a16;
    logic [CFG_A_BITS-1:0]  a8;
    logic [CFG_A_BITS-1:0]  a5;
    logic [CFG_A_BITS-1:0]  a4;
    logic [CFG_BLEND_B-1:0] blend;
    logic [CFG_DLY_B-1:0]   delay;
    logic [CFG_FDB_B-1:0]   feedbk;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{a16: RST_A16, a8: RST_A8, a5: RST_A5, a4: RST_A4,
                                 blend: RST_BLEND, delay: RST_DELAY, feedbk: RST_FEEDBK};

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_EVAL  = 2'd2
  } rx_state_t;

  // Apply one register write to a configuration record; the command
  // address and unmapped addresses leave the record untouched.
  function automatic cfg_t cfg_write(input cfg_t cur, input logic [2:0] addr,
                                     input logic [15:0] data);
    cfg_t nxt;
    nxt = cur;
    case (addr)
      ADDR_DRAW: begin
        nxt.a16 = data[4*CFG_A_BITS-1 -: CFG_A_BITS];
        nxt.a8  = data[3*CFG_A_BITS-1 -: CFG_A_BITS];
        nxt.a5  = data[2*CFG_A_BITS-1 -: CFG_A_BITS];
        nxt.a4  = data[CFG_A_BITS-1:0];
      end
      ADDR_BLEND: nxt.blend  = data[CFG_BLEND_B-1:0];
      ADDR_DELAY: nxt.delay  = data[CFG_DLY_B-1:0];
      ADDR_FDBK:  nxt.feedbk = data[CFG_FDB_B-1:0];
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ctrl_spi_regs_rx.sv
// spi_frame_rx
// Synchronizes the asynchronous SPI pins into clk, detects edges, shifts in
// MSB-first bits while the frame is selected and classifies the frame on
// deselect.
// Ports: clk, reset (async, active-high); sclk, mosi, ss_n (async pins);
//        frame_valid / frame_err (one-cycle strobes, in the EVAL cycle);
//        frame (received 24 bits, meaningful with the strobes).
module spi_frame_rx
  import ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [FRAME_BITS-1:0] frame
);

  localparam logic [4:0] CNT_FRAME = 5'd24;
  localparam logic [4:0] CNT_SAT   = 5'd25;

  logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, ss_sync_r;
  logic                   sclk_hist_r, ss_hist_r;
  logic                   sclk_rise_s, ss_fall_s, ss_rise_s, mosi_s;
  rx_state_t              state_r, state_nxt_s;
  logic [4:0]             cnt_r, cnt_nxt_s;
  logic [FRAME_BITS-1:0]  shreg_r, shreg_nxt_s;

  // Pin synchronizers plus one history flop for edge detection; ss_n idles high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '0;
      ss_sync_r   <= '1;
      sclk_hist_r <= 1'b0;
      ss_hist_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_n};
      sclk_hist_r <= sclk_sync_r[SYNC_STAGES-1];
      ss_hist_r   <= ss_sync_r[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_s = sclk_sync_r[SYNC_STAGES-1] & ~sclk_hist_r;
  assign ss_fall_s   = ~ss_sync_r[SYNC_STAGES-1] & ss_hist_r;
  assign ss_rise_s   = ss_sync_r[SYNC_STAGES-1] & ~ss_hist_r;
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];

  // Receive FSM state, bit counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RX_IDLE;
      cnt_r   <= 5'd0;
      shreg_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      shreg_r <= shreg_nxt_s;
    end
  end

  // Next-state logic; deselect wins over a coincident SCLK edge
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    shreg_nxt_s = shreg_r;
    case (state_r)
      RX_IDLE: begin
        if (ss_fall_s) begin
          cnt_nxt_s   = 5'd0;
          state_nxt_s = RX_SHIFT;
        end else begin
          state_nxt_s = RX_IDLE;
        end
      end
      RX_SHIFT: begin
        if (ss_rise_s) begin
          state_nxt_s = RX_EVAL;
        end else if (sclk_rise_s) begin
          shreg_nxt_s = {shreg_r[FRAME_BITS-2:0], mosi_s};
          // Saturating at 25 keeps over-long frames distinguishable from 24
          if (cnt_r != CNT_SAT) begin
            cnt_nxt_s = cnt_r + 5'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end else begin
          state_nxt_s = RX_SHIFT;
        end
      end
      RX_EVAL: state_nxt_s = RX_IDLE;
      default: state_nxt_s = RX_IDLE;
    endcase
  end

  assign frame_valid = (state_r == RX_EVAL) && (cnt_r == CNT_FRAME);
  assign frame_err   = (state_r == RX_EVAL) && (cnt_r != CNT_FRAME);
  assign frame       = shreg_r;

endmodule

// File: rtl/ctrl_spi_regs.sv
// ctrl_spi_regs
// SPI-slave control register bank for the tone/delay datapath. Received
// write frames land in shadow registers; shadow values are copied to the
// outputs atomically on a sample_tick while an update is pending.
// Ports: clk_50, reset (async, active-high); ctrl_sclk/ctrl_mosi/ctrl_ss_n
//        (async SPI pins, mode 0); sample_tick (one-cycle audio tick);
//        a16/a8/a5/a4, blend, delay, feedbk (committed configuration);
//        cfg_update (pulse in the cycle new values appear);
//        frame_err_cnt (saturating bad-frame count).
module ctrl_spi_regs
  import ctrl_pkg::*;
#(
  parameter int A_BITS      = CFG_A_BITS,
  parameter int BLEND_B     = CFG_BLEND_B,
  parameter int DLY_B       = CFG_DLY_B,
  parameter int FDB_B       = CFG_FDB_B,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_50,
  input  logic               reset,
  input  logic               ctrl_sclk,
  input  logic               ctrl_mosi,
  input  logic               ctrl_ss_n,
  input  logic               sample_tick,
  output logic [A_BITS-1:0]  a16,
  output logic [A_BITS-1:0]  a8,
  output logic [A_BITS-1:0]  a5,
  output logic [A_BITS-1:0]  a4,
  output logic [BLEND_B-1:0] blend,
  output logic [DLY_B-1:0]   delay,
  output logic [FDB_B-1:0]   feedbk,
  output logic               cfg_update,
  output logic [7:0]         frame_err_cnt
);

  logic                  frame_valid_s, frame_err_s;
  logic [FRAME_BITS-1:0] frame_s;
  logic [2:0]            addr_s;
  logic [15:0]           data_s;
  logic                  wr_ok_s, bad_s, set_pend_s, commit_s;
  cfg_t                  shadow_r, out_r;
  logic                  auto_r, pending_r, cfg_update_r;
  logic [7:0]            err_cnt_r;

  spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk         (clk_50),
    .reset       (reset),
    .sclk        (ctrl_sclk),
    .mosi        (ctrl_mosi),
    .ss_n        (ctrl_ss_n),
    .frame_valid (frame_valid_s),
    .frame_err   (frame_err_s),
    .frame       (frame_s)
  );

  assign addr_s   = frame_s[18:16];
  assign data_s   = frame_s[15:0];
  // Read frames (W=0) are accepted silently; there is nothing to read back
  assign wr_ok_s  = frame_valid_s && frame_s[23] && (addr_s <= ADDR_CMD);
  assign bad_s    = frame_err_s || (frame_valid_s && (addr_s > ADDR_CMD));
  assign set_pend_s = wr_ok_s && ((addr_s == ADDR_CMD) ? data_s[0] : auto_r);
  // Uses the registered pending, so a pending set this cycle waits a tick
  assign commit_s = sample_tick && pending_r;

  // Shadow registers, auto flag and pending flag
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      shadow_r  <= CFG_RESET;
      auto_r    <= 1'b0;
      pending_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        shadow_r <= cfg_write(shadow_r, addr_s, data_s);
      end
      if (wr_ok_s && (addr_s == ADDR_CMD)) begin
        auto_r <= data_s[1];
      end
      // A set in the committing cycle keeps pending for the next tick
      if (set_pend_s) begin
        pending_r <= 1'b1;
      end else if (commit_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  // Output registers: commit copies the pre-write shadow value
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      out_r        <= CFG_RESET;
      cfg_update_r <= 1'b0;
    end else begin
      cfg_update_r <= commit_s;
      if (commit_s) begin
        out_r <= shadow_r;
      end
    end
  end

  // Saturating bad-frame counter
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      err_cnt_r <= 8'd0;
    end else if (bad_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign a16           = out_r.a16;
  assign a8            = out_r.a8;
  assign a5            = out_r.a5;
  assign a4            = out_r.a4;
  assign blend         = out_r.blend;
  assign delay         = out_r.delay;
  assign feedbk        = out_r.feedbk;
  assign cfg_update    = cfg_update_r;
  assign frame_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_ctrl_spi_regs.sv
// tb_ctrl_spi_regs
// Directed self-checking bench for ctrl_spi_regs: SPI frames are bit-banged
// on the pins, expected values are hand-computed constants.
module tb_ctrl_spi_regs;

  logic        clk_50 = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_sclk = 1'b0;
  logic        ctrl_mosi = 1'b0;
  logic        ctrl_ss_n = 1'b1;
  logic        sample_tick = 1'b0;
  logic [2:0]  a16, a8, a5, a4;
  logic [3:0]  blend;
  logic [13:0] delay;
  logic [9:0]  feedbk;
  logic        cfg_update;
  logic [7:0]  frame_err_cnt;

  int errors = 0;
  int checks = 0;

  always #10 clk_50 = ~clk_50;

  ctrl_spi_regs dut (
    .clk_50        (clk_50),
    .reset         (reset),
    .ctrl_sclk     (ctrl_sclk),
    .ctrl_mosi     (ctrl_mosi),
    .ctrl_ss_n     (ctrl_ss_n),
    .sample_tick   (sample_tick),
    .a16           (a16),
    .a8            (a8),
    .a5            (a5),
    .a4            (a4),
    .blend         (blend),
    .delay         (delay),
    .feedbk        (feedbk),
    .cfg_update    (cfg_update),
    .frame_err_cnt (frame_err_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] e16, input logic [31:0] e8,
                           input logic [31:0] e5, input logic [31:0] e4, input logic [31:0] ebl,
                           input logic [31:0] edl, input logic [31:0] efb);
    check_val({tag, ".a16"},    32'(a16),    e16);
    check_val({tag, ".a8"},     32'(a8),     e8);
    check_val({tag, ".a5"},     32'(a5),     e5);
    check_val({tag, ".a4"},     32'(a4),     e4);
    check_val({tag, ".blend"},  32'(blend),  ebl);
    check_val({tag, ".delay"},  32'(delay),  edl);
    check_val({tag, ".feedbk"}, 32'(feedbk), efb);
  endtask

  // Select the slave and clock out the low n bits of v, MSB first; SCLK
  // half periods of 5 clk_50 cycles
  task automatic frame_bits(input logic [31:0] v, input int n);
    @(negedge clk_50) ctrl_ss_n = 1'b0;
    repeat (5) @(negedge clk_50);
    for (int i = n - 1; i >= 0; i--) begin
      ctrl_mosi = v[i];
      repeat (5) @(negedge clk_50);
      ctrl_sclk = 1'b1;
      repeat (5) @(negedge clk_50);
      ctrl_sclk = 1'b0;
    end
    repeat (5) @(negedge clk_50);
  endtask

  task automatic frame_end();
    @(negedge clk_50) ctrl_ss_n = 1'b1;
    repeat (10) @(negedge clk_50);
  endtask

  task automatic send(input logic [31:0] v, input int n);
    frame_bits(v, n);
    frame_end();
  endtask

  // One-cycle tick; returns on the negedge after the committing posedge
  task automatic tick();
    @(negedge clk_50) sample_tick = 1'b1;
    @(negedge clk_50) sample_tick = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk_50);
    reset = 1'b0;
    @(negedge clk_50);
    check_out("rst", 7, 4, 0, 0, 0, 0, 0);
    check_val("rst.cfg_update", 32'(cfg_update), 0);
    check_val("rst.err_cnt", 32'(frame_err_cnt), 0);

    // Drawbar write, explicit commit
    send(32'h0080_0ABC, 24);
    check_out("draw_shadow_only", 7, 4, 0, 0, 0, 0, 0);
    send(32'h0084_0001, 24);
    check_val("draw_pre_tick.a16", 32'(a16), 7);
    check_val("draw_pre_tick.cfg_update", 32'(cfg_update), 0);
    tick();
    check_val("draw.cfg_update", 32'(cfg_update), 1);
    check_out("draw", 5, 2, 7, 4, 0, 0, 0);
    @(negedge clk_50);
    check_val("draw.cfg_update_pulse", 32'(cfg_update), 0);

    // Auto mode: enabling it alone commits nothing
    send(32'h0084_0002, 24);
    tick();
    check_val("auto_only.cfg_update", 32'(cfg_update), 0);
    send(32'h0082_3FFF, 24);
    tick();
    check_val("auto.cfg_update", 32'(cfg_update), 1);
    check_out("auto", 5, 2, 7, 4, 0, 32'h3FFF, 0);

    // Bad frames: 23 bits (would decode as blend=6), 25 bits, addr 6
    send(32'h0001_0006, 23);
    send(32'h0181_0005, 25);
    send(32'h0086_0001, 24);
    check_val("bad.err_cnt", 32'(frame_err_cnt), 3);
    tick();
    check_val("bad.cfg_update", 32'(cfg_update), 0);
    check_out("bad", 5, 2, 7, 4, 0, 32'h3FFF, 0);

    // Read frame has no effect
    send(32'h0003_FFFF, 24);
    check_val("read.err_cnt", 32'(frame_err_cnt), 3);
    tick();
    check_val("read.cfg_update", 32'(cfg_update), 0);
    check_val("read.feedbk", 32'(feedbk), 0);

    // Tick coincides with EVAL of a feedbk write while 0x155 is pending
    send(32'h0083_0155, 24);
    frame_bits(32'h0083_02AA, 24);
    @(negedge clk_50) ctrl_ss_n = 1'b1;
    repeat (3) @(negedge clk_50);
    sample_tick = 1'b1;
    @(negedge clk_50) sample_tick = 1'b0;
    check_val("simul.cfg_update", 32'(cfg_update), 1);
    check_val("simul.feedbk_old", 32'(feedbk), 32'h155);
    repeat (10) @(negedge clk_50);
    check_val("simul.feedbk_stable", 32'(feedbk), 32'h155);
    tick();
    check_val("simul_next.cfg_update", 32'(cfg_update), 1);
    check_val("simul_next.feedbk", 32'(feedbk), 32'h2AA);

    // Error counter saturation with short frames
    for (int k = 0; k < 300; k++) begin
      send(32'h0000_0001, 1);
    end
    check_val("sat.err_cnt", 32'(frame_err_cnt), 255);

    // Reset in the middle of a frame
    frame_bits(32'h0083_0077, 12);
    @(negedge clk_50);
    reset = 1'b1;
    ctrl_ss_n = 1'b1;
    ctrl_sclk = 1'b0;
    repeat (3) @(negedge clk_50);
    reset = 1'b0;
    repeat (5) @(negedge clk_50);
    check_out("midrst", 7, 4, 0, 0, 0, 0, 0);
    check_val("midrst.cfg_update", 32'(cfg_update), 0);
    check_val("midrst.err_cnt", 32'(frame_err_cnt), 0);
    send(32'h0081_0009, 24);
    send(32'h0084_0001, 24);
    tick();
    check_val("postrst.cfg_update", 32'(cfg_update), 1);
    check_out("postrst", 7, 4, 0, 0, 9, 0, 0);
    check_val("postrst.err_cnt", 32'(frame_err_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
